// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit bus: grants select codes 1..7,
// holds memory (code 7) for MEM_WAIT extra cycles, pulses done per transfer.
module bus_arbiter #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] req,
  output logic [2:0] bselect,
  output logic [6:0] grant,
  output logic       done,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MWAIT, XFER} state_t;

  state_t     state_q, state_d;
  logic [2:0] win_q, win_d;
  logic [2:0] last_q, last_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [2:0] bselect_q, bselect_d;
  logic [6:0] grant_q, grant_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  logic [6:0] cand;
  logic [2:0] pick;
  logic       hit;

  function automatic logic [6:0] onehot(input logic [2:0] code);
    logic [6:0] r;
    r = '0;
    if (code != 3'd0) r[code - 3'd1] = 1'b1;
    return r;
  endfunction

  // Scan codes starting after last, wrapping 7->1; the code just served is
  // masked because its requester still holds req during the done cycle.
  always_comb begin
    cand = req & ~((state_q == XFER) ? onehot(win_q) : '0);
    pick = '0;
    hit  = 1'b0;
    for (int unsigned k = 1; k <= 7; k++) begin
      int unsigned c;
      logic [2:0]  idx;
      c   = ((32'(last_q) + k - 1) % 7) + 1;
      idx = 3'(c - 1);
      if (!hit && cand[idx]) begin
        hit  = 1'b1;
        pick = 3'(c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE, XFER: begin
        if (hit) begin
          win_d  = pick;
          last_d = pick;
          if (pick == 3'd7 && MEM_WAIT != 0) begin
            state_d = MWAIT;
            wcnt_d  = 4'(MEM_WAIT - 1);
          end else begin
            state_d = XFER;
          end
        end else begin
          state_d = IDLE;
          win_d   = '0;
        end
      end
      MWAIT: begin
        if (!req[6]) begin
          state_d = IDLE;
          win_d   = '0;
        end else if (wcnt_q == 4'd0) begin
          state_d = XFER;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        win_d   = '0;
      end
    endcase

    bselect_d = (state_d == IDLE) ? 3'd0 : win_d;
    grant_d   = onehot(bselect_d);
    done_d    = (state_d == XFER);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_q     <= '0;
      last_q    <= 3'd7;
      wcnt_q    <= '0;
      bselect_q <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      wcnt_q    <= wcnt_d;
      bselect_q <= bselect_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bselect = bselect_q;
  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: two arbiters (MEM_WAIT=2 and MEM_WAIT=0) share stimulus;
// a transaction-level model predicts every cycle's outputs for each.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] req;
  logic [2:0] bsel2, bsel0;
  logic [6:0] grant2, grant0;
  logic       done2, done0, busy2, busy0;

  int    total = 0;
  int    bad   = 0;
  string phase = "reset";

  always #5 clk = ~clk;

  bus_arbiter #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .bselect(bsel2), .grant(grant2), .done(done2), .busy(busy2)
  );

  bus_arbiter #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .bselect(bsel0), .grant(grant0), .done(done0), .busy(busy0)
  );

  // owner: code on the bus (0 = none); hold: cycles still to wait before done
  typedef struct {
    int owner;
    int hold;
    int last;
  } ms_t;

  function automatic ms_t step(input ms_t s, input logic [6:0] r, input logic rn, input int mw);
    ms_t n;
    int  c;
    n = s;
    if (!rn) begin
      n.owner = 0; n.hold = 0; n.last = 7;
      return n;
    end
    if (s.owner != 0 && s.hold > 0) begin
      if (!r[6]) begin
        n.owner = 0; n.hold = 0;
      end else begin
        n.hold = s.hold - 1;
      end
      return n;
    end
    n.owner = 0;
    n.hold  = 0;
    for (int k = 1; k <= 7; k++) begin
      c = ((s.last + k - 1) % 7) + 1;
      if (c != s.owner && r[c-1]) begin
        n.owner = c;
        n.last  = c;
        n.hold  = (c == 7) ? mw : 0;
        break;
      end
    end
    return n;
  endfunction

  function automatic logic [11:0] outs(input ms_t s);
    logic [2:0] bs;
    logic [6:0] g;
    bs = 3'(s.owner);
    g  = (s.owner != 0) ? 7'(1 << (s.owner - 1)) : 7'd0;
    return {bs, g, (s.owner != 0 && s.hold == 0), (s.owner != 0)};
  endfunction

  logic [11:0] q2[$];
  logic [11:0] q0[$];

  initial begin
    ms_t m2, m0;
    m2 = '{owner: 0, hold: 0, last: 7};
    m0 = '{owner: 0, hold: 0, last: 7};
    forever begin
      @(posedge clk);
      m2 = step(m2, req, rst_n, 2);
      m0 = step(m0, req, rst_n, 0);
      q2.push_back(outs(m2));
      q0.push_back(outs(m0));
    end
  end

  task automatic cmp(input string name, input logic [11:0] exp, input logic [11:0] got);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s phase=%s t=%0t got bsel=%0d grant=%b done=%b busy=%b expected bsel=%0d grant=%b done=%b busy=%b",
               name, phase, $time, got[11:9], got[8:2], got[1], got[0],
               exp[11:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q2.size() == 0 || q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty phase=%s t=%0t", phase, $time);
      end else begin
        cmp("mw2", q2.pop_front(), {bsel2, grant2, done2, busy2});
        cmp("mw0", q0.pop_front(), {bsel0, grant0, done0, busy0});
      end
    end
  end

  task automatic drive(input logic [6:0] r, input int n);
    repeat (n) begin
      req = r;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [6:0] cur;
    rst_n = 1'b0;
    req   = 7'h7F;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    phase = "rr_all";
    drive(7'h7F, 14);
    drive(7'h00, 4);

    phase = "single3";
    drive(7'b0000100, 2);
    drive(7'h00, 2);

    phase = "mem_abandon";
    drive(7'b1000000, 2);
    drive(7'h00, 3);

    phase = "mem_full";
    drive(7'b1000000, 3);
    drive(7'h00, 3);

    phase = "reset_in_mwait";
    drive(7'b1000000, 1);
    rst_n = 1'b0;
    drive(7'h7F, 1);
    rst_n = 1'b1;
    drive(7'h7F, 3);
    drive(7'h00, 3);

    phase = "random";
    cur = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0)
        cur = ($urandom_range(0, 1) == 0) ? 7'($urandom) : 7'($urandom) & 7'($urandom);
      rst_n = ($urandom_range(0, 59) != 0);
      drive(cur, 1);
    end
    rst_n = 1'b1;
    drive(7'h00, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
